// File: rtl/gcn_index_sequencer.sv
// gcn_index_sequencer
//   Walks the (row, col, k) loop nest for one GCN dense matmul pass,
//   out[row][col] = sum_k feat[row][k] * wgt[k][col], and emits one
//   beat per valid/ready handshake carrying the indices plus flat feature
//   and weight SRAM addresses. The addresses are kept up to date with
//   incremental adders (running row base and strides), not multipliers.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   start, abort          pass control from the layer controller
//   num_rows/cols/k       run-time loop bounds, sampled on an accepted start
//   ready / valid         beat handshake toward the SRAM ports and MAC array
//   row_idx/col_idx/k_idx current indices
//   feat_addr, wgt_addr   row*num_k + k, k*num_cols + col
//   first_k, last_k       accumulator clear / result write markers
//   last                  final beat of the pass
//   busy, done            not idle; one-cycle end-of-pass pulse
//   err_bound             sticky flag for a start with an illegal bound
module gcn_index_sequencer #(
  parameter int MAX_ROWS = 6,
  parameter int MAX_COLS = 3,
  parameter int MAX_K    = 96,
  parameter int ROW_W    = $clog2(MAX_ROWS),
  parameter int COL_W    = $clog2(MAX_COLS),
  parameter int K_W      = $clog2(MAX_K),
  parameter int FADDR_W  = $clog2(MAX_ROWS*MAX_K),
  parameter int WADDR_W  = $clog2(MAX_K*MAX_COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [ROW_W:0]     num_rows,
  input  logic [COL_W:0]     num_cols,
  input  logic [K_W:0]       num_k,
  input  logic               ready,
  output logic               valid,
  output logic [ROW_W-1:0]   row_idx,
  output logic [COL_W-1:0]   col_idx,
  output logic [K_W-1:0]     k_idx,
  output logic [FADDR_W-1:0] feat_addr,
  output logic [WADDR_W-1:0] wgt_addr,
  output logic               first_k,
  output logic               last_k,
  output logic               last,
  output logic               busy,
  output logic               done,
  output logic               err_bound
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Bounds are stored pre-decremented (for wrap compares) and zero-extended
  // to address width (as adder strides), so nothing is resized per beat.
  typedef struct packed {
    logic [ROW_W-1:0]   row_last;
    logic [COL_W-1:0]   col_last;
    logic [K_W-1:0]     k_last;
    logic [FADDR_W-1:0] fstride;  // num_k: feature row pitch
    logic [WADDR_W-1:0] wstride;  // num_cols: weight row pitch
  } bounds_t;

  state_t             state, state_nxt;
  bounds_t            bnd, bnd_nxt;
  logic [ROW_W-1:0]   row_nxt;
  logic [COL_W-1:0]   col_nxt;
  logic [K_W-1:0]     k_nxt;
  logic [FADDR_W-1:0] feat_nxt, row_base, base_nxt;
  logic [WADDR_W-1:0] wgt_nxt;
  logic               err_nxt;
  logic               bad_bound, clear_idx;
  logic               k_wrap, col_wrap, row_wrap;

  assign bad_bound = (num_rows == '0) || (num_rows > (ROW_W+1)'(MAX_ROWS)) ||
                     (num_cols == '0) || (num_cols > (COL_W+1)'(MAX_COLS)) ||
                     (num_k    == '0) || (num_k    > (K_W+1)'(MAX_K));

  assign k_wrap   = (k_idx   == bnd.k_last);
  assign col_wrap = (col_idx == bnd.col_last);
  assign row_wrap = (row_idx == bnd.row_last);

  assign valid     = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign first_k   = valid && (k_idx == '0);
  assign last_k    = valid && k_wrap;
  assign last      = last_k && col_wrap && row_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bnd       <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      k_idx     <= '0;
      feat_addr <= '0;
      wgt_addr  <= '0;
      row_base  <= '0;
      err_bound <= 1'b0;
    end else begin
      state     <= state_nxt;
      bnd       <= bnd_nxt;
      row_idx   <= row_nxt;
      col_idx   <= col_nxt;
      k_idx     <= k_nxt;
      feat_addr <= feat_nxt;
      wgt_addr  <= wgt_nxt;
      row_base  <= base_nxt;
      err_bound <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bnd_nxt   = bnd;
    row_nxt   = row_idx;
    col_nxt   = col_idx;
    k_nxt     = k_idx;
    feat_nxt  = feat_addr;
    wgt_nxt   = wgt_addr;
    base_nxt  = row_base;
    err_nxt   = err_bound;
    clear_idx = 1'b0;
    case (state)
      S_IDLE: begin
        // abort outranks start even here, so a coincident pair does nothing
        if (start && !abort) begin
          if (bad_bound) begin
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            err_nxt          = 1'b0;
            state_nxt        = S_RUN;
            clear_idx        = 1'b1;
            bnd_nxt.row_last = ROW_W'(num_rows - (ROW_W+1)'(1));
            bnd_nxt.col_last = COL_W'(num_cols - (COL_W+1)'(1));
            bnd_nxt.k_last   = K_W'(num_k - (K_W+1)'(1));
            bnd_nxt.fstride  = FADDR_W'(num_k);
            bnd_nxt.wstride  = WADDR_W'(num_cols);
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
          clear_idx = 1'b1;
        end else if (ready) begin
          if (!k_wrap) begin
            k_nxt    = k_idx + K_W'(1);
            feat_nxt = feat_addr + FADDR_W'(1);
            wgt_nxt  = wgt_addr + bnd.wstride;
          end else if (!col_wrap) begin
            // new column: weight walk restarts at row 0 of that column,
            // feature walk restarts at the head of the current row
            k_nxt    = '0;
            col_nxt  = col_idx + COL_W'(1);
            wgt_nxt  = WADDR_W'(col_idx) + WADDR_W'(1);
            feat_nxt = row_base;
          end else if (!row_wrap) begin
            k_nxt    = '0;
            col_nxt  = '0;
            row_nxt  = row_idx + ROW_W'(1);
            base_nxt = row_base + bnd.fstride;
            feat_nxt = row_base + bnd.fstride;
            wgt_nxt  = '0;
          end else begin
            state_nxt = S_DONE;
            clear_idx = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        clear_idx = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clear_idx) begin
      row_nxt  = '0;
      col_nxt  = '0;
      k_nxt    = '0;
      feat_nxt = '0;
      wgt_nxt  = '0;
      base_nxt = '0;
    end
  end

endmodule
